bwt_mem_responder: RTL and testbench

- Responder side of the backward-control memory request interface (request_valid / addr_k / addr_l).
- Buffers each k/l address pair and issues two 512-bit cache-line reads to memory, k first, then l.
- Reassembles the in-order memory responses into one {k line, l line} result, tagged with read_num, for the occ/ok computation in the next backward iteration.
- Provides an almost-full back-pressure signal for driving the pipeline stall.

---
 rtl/bwt_mem_responder_if.sv | 35 +++
 rtl/bwt_mem_responder.sv | 142 ++++++++++++++
 tb/tb_bwt_mem_responder.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/bwt_mem_responder_if.sv
// bwt_mem_responder_if: request, memory read/response and assembled-result signals of bwt_mem_responder
interface bwt_mem_responder_if;
  logic         request_valid;
  logic [41:0]  addr_k;
  logic [41:0]  addr_l;
  logic [8:0]   req_read_num;
  logic         req_almost_full;
  logic         overflow;
  logic         mem_rd_valid;
  logic [41:0]  mem_rd_addr;
  logic [9:0]   mem_rd_tag;
  logic         mem_rd_ready;
  logic         mem_rsp_valid;
  logic [511:0] mem_rsp_data;
  logic [9:0]   mem_rsp_tag;
  logic         mem_rsp_ready;
  logic         resp_valid;
  logic [8:0]   resp_read_num;
  logic [511:0] resp_cl_k;
  logic [511:0] resp_cl_l;
  logic         resp_ready;
  logic         tag_err;
  modport slave (
    input  request_valid, addr_k, addr_l, req_read_num, mem_rd_ready,
           mem_rsp_valid, mem_rsp_data, mem_rsp_tag, resp_ready,
    output req_almost_full, overflow, mem_rd_valid, mem_rd_addr, mem_rd_tag,
           mem_rsp_ready, resp_valid, resp_read_num, resp_cl_k, resp_cl_l, tag_err
  );
  modport master (
    output request_valid, addr_k, addr_l, req_read_num, mem_rd_ready,
           mem_rsp_valid, mem_rsp_data, mem_rsp_tag, resp_ready,
    input  req_almost_full, overflow, mem_rd_valid, mem_rd_addr, mem_rd_tag,
           mem_rsp_ready, resp_valid, resp_read_num, resp_cl_k, resp_cl_l, tag_err
  );
endinterface

// File: rtl/bwt_mem_responder.sv
// bwt_mem_responder: buffers k/l address pairs, issues paired cache-line reads and reassembles the responses
module bwt_mem_responder #(
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_OUT = 4,
  parameter int AF_MARGIN = 3
) (
  input logic clk,
  input logic rst,
  bwt_mem_responder_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int OW = $clog2(MAX_OUT + 1);
  localparam int TW = $clog2(MAX_OUT * 2);
  typedef enum logic [1:0] {ISS_IDLE, ISS_K, ISS_L} iss_t;
  typedef enum logic [1:0] {RET_K, RET_L, RET_OUT} ret_t;
  logic [92:0] fifo_mem [FIFO_DEPTH];
  logic [9:0] tag_mem [MAX_OUT*2];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic [OW-1:0] out_q, out_d;
  logic [TW-1:0] tw_ptr_q, tr_ptr_q;
  iss_t iss_q, iss_d;
  ret_t ret_q, ret_d;
  logic [92:0] head;
  logic [41:0] addr_l_q, mem_rd_addr_q;
  logic [9:0] mem_rd_tag_q, exp_tag;
  logic [8:0] resp_read_num_q;
  logic [511:0] resp_cl_k_q, resp_cl_l_q;
  logic mem_rd_valid_q, mem_rsp_ready_q, resp_valid_q, af_q, overflow_q, tag_err_q;
  logic full, empty, push, pop, rd_fire, rsp_fire, k_acc, inc, dec;

  // FIFO control, outstanding accounting and next-state decode for both FSMs
  always_comb begin
    head = fifo_mem[rd_ptr_q];
    exp_tag = tag_mem[tr_ptr_q];
    full = count_q == (AW+1)'(FIFO_DEPTH);
    empty = count_q == '0;
    pop = iss_q == ISS_IDLE && !empty && out_q < OW'(MAX_OUT);
    push = bus.request_valid && (!full || pop);
    rd_fire = mem_rd_valid_q && bus.mem_rd_ready;
    rsp_fire = bus.mem_rsp_valid && mem_rsp_ready_q;
    k_acc = iss_q == ISS_K && bus.mem_rd_ready;
    inc = iss_q == ISS_L && bus.mem_rd_ready;
    dec = resp_valid_q && bus.resp_ready;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    out_d = out_q + OW'(inc) - OW'(dec);
    iss_d = pop ? ISS_K : k_acc ? ISS_L : inc ? ISS_IDLE : iss_q;
    ret_d = (ret_q == RET_K && rsp_fire) ? RET_L :
            (ret_q == RET_L && rsp_fire) ? RET_OUT :
            dec ? RET_K : ret_q;
  end

  // request and expected-tag storage; contents need no reset because pointers gate every read
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= {bus.req_read_num, bus.addr_k, bus.addr_l};
    if (rd_fire) tag_mem[tw_ptr_q] <= mem_rd_tag_q;
  end

  // FIFO pointers, counters, back-pressure and sticky error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      out_q <= '0;
      tw_ptr_q <= '0;
      tr_ptr_q <= '0;
      af_q <= 1'b0;
      overflow_q <= 1'b0;
      tag_err_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      out_q <= out_d;
      tw_ptr_q <= rd_fire ? tw_ptr_q + TW'(1) : tw_ptr_q;
      tr_ptr_q <= rsp_fire ? tr_ptr_q + TW'(1) : tr_ptr_q;
      af_q <= count_d >= (AW+1)'(FIFO_DEPTH - AF_MARGIN);
      overflow_q <= overflow_q | (bus.request_valid && full && !pop);
      tag_err_q <= tag_err_q | (rsp_fire && bus.mem_rsp_tag != exp_tag);
    end
  end

  // issue FSM: latch the head, present k then l, holding address/tag until accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iss_q <= ISS_IDLE;
      mem_rd_valid_q <= 1'b0;
      mem_rd_addr_q <= '0;
      mem_rd_tag_q <= '0;
      addr_l_q <= '0;
    end else begin
      iss_q <= iss_d;
      if (pop) begin
        mem_rd_valid_q <= 1'b1;
        mem_rd_addr_q <= head[83:42];
        mem_rd_tag_q <= {head[92:84], 1'b0};
        addr_l_q <= head[41:0];
      end else if (k_acc) begin
        mem_rd_addr_q <= addr_l_q;
        mem_rd_tag_q[0] <= 1'b1;
      end else if (inc) begin
        mem_rd_valid_q <= 1'b0;
      end
    end
  end

  // return FSM: collect k then l line, then hold the assembled result until taken
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ret_q <= RET_K;
      mem_rsp_ready_q <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_read_num_q <= '0;
      resp_cl_k_q <= '0;
      resp_cl_l_q <= '0;
    end else begin
      ret_q <= ret_d;
      mem_rsp_ready_q <= ret_d != RET_OUT;
      resp_valid_q <= ret_d == RET_OUT;
      if (ret_q == RET_K && rsp_fire) begin
        resp_cl_k_q <= bus.mem_rsp_data;
        resp_read_num_q <= exp_tag[9:1];
      end
      if (ret_q == RET_L && rsp_fire) resp_cl_l_q <= bus.mem_rsp_data;
    end
  end

  assign bus.req_almost_full = af_q;
  assign bus.overflow = overflow_q;
  assign bus.mem_rd_valid = mem_rd_valid_q;
  assign bus.mem_rd_addr = mem_rd_addr_q;
  assign bus.mem_rd_tag = mem_rd_tag_q;
  assign bus.mem_rsp_ready = mem_rsp_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_read_num = resp_read_num_q;
  assign bus.resp_cl_k = resp_cl_k_q;
  assign bus.resp_cl_l = resp_cl_l_q;
  assign bus.tag_err = tag_err_q;
endmodule

// File: tb/tb_bwt_mem_responder.sv
// tb_bwt_mem_responder: directed checks of issue, reassembly, back-pressure, tag checking and reset
module tb_bwt_mem_responder;
  logic clk = 1'b0;
  logic rst;
  logic flush, bad_tag, hold_l, rd_en;
  int cyc = 0;
  int total = 0;
  int bad = 0;
  int base, d0;
  logic [511:0] s_k, s_l;
  logic [8:0] s_rn;

  typedef struct packed {logic [9:0] tag; logic [41:0] addr; int due;} rd_t;
  typedef struct packed {logic [8:0] rn; logic [41:0] k; logic [41:0] l;} dl_t;
  rd_t mq[$];
  logic [9:0] tags[$];
  dl_t dlv[$];

  bwt_mem_responder_if bus();
  bwt_mem_responder dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [511:0] line(input logic [41:0] a);
    return {8'hA5, {12{a}}};
  endfunction

  // memory accepts reads unless the l half is deliberately held back
  always_comb bus.mem_rd_ready = rd_en && !(hold_l && bus.mem_rd_tag[0]);

  // memory model bookkeeping: log issued reads, retire accepted responses, log delivered results
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (flush) mq.delete();
    else begin
      if (bus.mem_rd_valid && bus.mem_rd_ready) begin
        mq.push_back({bus.mem_rd_tag, bus.mem_rd_addr, cyc + 3});
        tags.push_back(bus.mem_rd_tag);
      end
      if (bus.mem_rsp_valid && bus.mem_rsp_ready && mq.size() > 0) void'(mq.pop_front());
      if (bus.resp_valid && bus.resp_ready) dlv.push_back({bus.resp_read_num, bus.resp_cl_k[41:0], bus.resp_cl_l[41:0]});
    end
  end

  // memory model response driver, in issue order after the latency has elapsed
  always @(negedge clk) begin
    if (!flush && mq.size() > 0 && cyc >= mq[0].due) begin
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data = line(mq[0].addr);
      bus.mem_rsp_tag = (bad_tag && mq[0].tag == 10'h00A) ? 10'h00C : mq[0].tag;
    end else begin
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data = '0;
      bus.mem_rsp_tag = '0;
    end
  end

  task automatic chk(input string t, input logic [511:0] o, input logic [511:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", t, o, e);
    end
  endtask

  task automatic send(input logic [8:0] rn, input logic [41:0] k, input logic [41:0] l);
    bus.request_valid = 1'b1;
    bus.req_read_num = rn;
    bus.addr_k = k;
    bus.addr_l = l;
    @(negedge clk);
    bus.request_valid = 1'b0;
  endtask

  task automatic wait_resp();
    for (int i = 0; i < 200 && !bus.resp_valid; i++) @(negedge clk);
    chk("resp_wait", bus.resp_valid, 1);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b1;
    bad_tag = 1'b0;
    hold_l = 1'b0;
    rd_en = 1'b1;
    bus.request_valid = 1'b0;
    bus.req_read_num = '0;
    bus.addr_k = '0;
    bus.addr_l = '0;
    bus.resp_ready = 1'b1;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rd_valid", bus.mem_rd_valid, 0);
    chk("rst_rsp_ready", bus.mem_rsp_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_af", bus.req_almost_full, 0);
    chk("rst_overflow", bus.overflow, 0);
    chk("rst_tag_err", bus.tag_err, 0);
    rst = 1'b1;
    flush = 1'b0;
    @(negedge clk);
    chk("idle_rsp_ready", bus.mem_rsp_ready, 1);
    // single request: two-cycle latency to the k read, then l, then the assembled result
    send(9'd5, 42'h100, 42'h104);
    chk("lat_1", bus.mem_rd_valid, 0);
    @(negedge clk);
    chk("lat_2", bus.mem_rd_valid, 1);
    chk("k_addr", bus.mem_rd_addr, 42'h100);
    chk("k_tag", bus.mem_rd_tag, 10'h00A);
    @(negedge clk);
    chk("l_valid", bus.mem_rd_valid, 1);
    chk("l_addr", bus.mem_rd_addr, 42'h104);
    chk("l_tag", bus.mem_rd_tag, 10'h00B);
    wait_resp();
    chk("s_rn", bus.resp_read_num, 5);
    chk("s_cl_k", bus.resp_cl_k, line(42'h100));
    chk("s_cl_l", bus.resp_cl_l, line(42'h104));
    @(negedge clk);
    chk("s_done", bus.resp_valid, 0);
    chk("s_out", dut.out_q, 0);
    // outstanding limit: four pairs in flight with the result stalled
    base = tags.size();
    d0 = dlv.size();
    bus.resp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(9'(10 + i), 42'h200 + 42'(16 * i), 42'h204 + 42'(16 * i));
    repeat (30) @(negedge clk);
    chk("lim_tags", tags.size() - base, 8);
    chk("lim_rd_valid", bus.mem_rd_valid, 0);
    chk("lim_resp_valid", bus.resp_valid, 1);
    chk("lim_rn", bus.resp_read_num, 10);
    chk("lim_rsp_ready", bus.mem_rsp_ready, 0);
    s_k = bus.resp_cl_k;
    s_l = bus.resp_cl_l;
    s_rn = bus.resp_read_num;
    // FIFO fill while nothing can issue: almost-full after the 13th write, 17th dropped
    for (int j = 0; j < 17; j++) begin
      send(9'(20 + j), 42'h400 + 42'(16 * j), 42'h404 + 42'(16 * j));
      if (j == 11) chk("af_12", bus.req_almost_full, 0);
      if (j == 12) chk("af_13", bus.req_almost_full, 1);
      if (j == 15) chk("ovf_16", bus.overflow, 0);
      if (j == 16) chk("ovf_17", bus.overflow, 1);
    end
    chk("fill_tags", tags.size() - base, 8);
    chk("bp_cl_k", bus.resp_cl_k, s_k);
    chk("bp_cl_l", bus.resp_cl_l, s_l);
    chk("bp_rn", bus.resp_read_num, s_rn);
    chk("bp_valid", bus.resp_valid, 1);
    chk("bp_rsp_ready", bus.mem_rsp_ready, 0);
    // one result taken lets exactly one more pair out
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    repeat (20) @(negedge clk);
    chk("pulse_tags", tags.size() - base, 10);
    chk("pulse_tag_k", tags[base + 8], {9'd20, 1'b0});
    chk("pulse_tag_l", tags[base + 9], {9'd20, 1'b1});
    chk("pulse_rd_valid", bus.mem_rd_valid, 0);
    chk("pulse_rn", bus.resp_read_num, 11);
    chk("pulse_cl_k", bus.resp_cl_k, line(42'h210));
    chk("pulse_cl_l", bus.resp_cl_l, line(42'h214));
    // drain everything and check delivery order and contents
    bus.resp_ready = 1'b1;
    for (int i = 0; i < 800 && dlv.size() < d0 + 20; i++) @(negedge clk);
    repeat (10) @(negedge clk);
    chk("drain_cnt", dlv.size() - d0, 20);
    for (int i = 0; i < 20; i++) begin
      chk("drain_rn", dlv[d0 + i].rn, i < 4 ? 9'(10 + i) : 9'(16 + i));
      chk("drain_k", dlv[d0 + i].k, i < 4 ? 42'h200 + 42'(16 * i) : 42'h400 + 42'(16 * (i - 4)));
      chk("drain_l", dlv[d0 + i].l, i < 4 ? 42'h204 + 42'(16 * i) : 42'h404 + 42'(16 * (i - 4)));
    end
    chk("drain_ovf", bus.overflow, 1);
    chk("drain_af", bus.req_almost_full, 0);
    chk("drain_tag_err", bus.tag_err, 0);
    chk("drain_out", dut.out_q, 0);
    // wrong k tag from memory: flagged, data still delivered, flag sticks
    bad_tag = 1'b1;
    send(9'd5, 42'h600, 42'h604);
    wait_resp();
    chk("te_flag", bus.tag_err, 1);
    chk("te_cl_k", bus.resp_cl_k, line(42'h600));
    chk("te_cl_l", bus.resp_cl_l, line(42'h604));
    bad_tag = 1'b0;
    @(negedge clk);
    send(9'd7, 42'h610, 42'h614);
    wait_resp();
    chk("te_next_rn", bus.resp_read_num, 7);
    chk("te_sticky", bus.tag_err, 1);
    @(negedge clk);
    // reset after k captured and l held back
    hold_l = 1'b1;
    send(9'd40, 42'h700, 42'h704);
    repeat (10) @(negedge clk);
    chk("mid_l_pending", bus.mem_rd_valid, 1);
    chk("mid_l_tag", bus.mem_rd_tag, {9'd40, 1'b1});
    chk("mid_k_held", bus.resp_cl_k, line(42'h700));
    chk("mid_no_resp", bus.resp_valid, 0);
    #2 rst = 1'b0;
    flush = 1'b1;
    #1;
    chk("ar_rd_valid", bus.mem_rd_valid, 0);
    chk("ar_rd_addr", bus.mem_rd_addr, 0);
    chk("ar_rd_tag", bus.mem_rd_tag, 0);
    chk("ar_rsp_ready", bus.mem_rsp_ready, 0);
    chk("ar_resp_valid", bus.resp_valid, 0);
    chk("ar_cl_k", bus.resp_cl_k, 0);
    chk("ar_rn", bus.resp_read_num, 0);
    chk("ar_overflow", bus.overflow, 0);
    chk("ar_tag_err", bus.tag_err, 0);
    @(negedge clk);
    rst = 1'b1;
    flush = 1'b0;
    hold_l = 1'b0;
    @(negedge clk);
    send(9'd41, 42'h800, 42'h804);
    wait_resp();
    chk("post_rn", bus.resp_read_num, 41);
    chk("post_cl_k", bus.resp_cl_k, line(42'h800));
    chk("post_cl_l", bus.resp_cl_l, line(42'h804));
    chk("post_tag_err", bus.tag_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
